// File: rtl/gate_access_controller_pkg.sv
// ----------------------------------------------------------------------------
// gate_pkg
// Shared types for the gate access controller and its occupancy register.
//   state_t : controller FSM states
//   side_t  : which gate the round-robin pointer currently favours
//   max2    : helper used to size the shared gate/alarm window timer
// ----------------------------------------------------------------------------
package gate_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OPEN_IN  = 3'd1,
    OPEN_OUT = 3'd2,
    DENY     = 3'd3,
    COOLDOWN = 3'd4
  } state_t;

  typedef enum logic {
    SIDE_IN  = 1'b0,
    SIDE_OUT = 1'b1
  } side_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gate_access_controller_occupancy_reg.sv
// ----------------------------------------------------------------------------
// occupancy_reg
// Occupancy counter shared by the entry and exit gates.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset (count -> 0)
//   inc_i    : add one occupant (only issued while not full)
//   dec_i    : remove one occupant (only issued while not empty)
//   pcount_o : registered occupancy
//   full_o   : pcount_o == CAPACITY
//   empty_o  : pcount_o == 0
// Flags are decoded from the registered count, so they always agree with
// pcount_o in the same cycle.
// ----------------------------------------------------------------------------
module occupancy_reg #(
  parameter int CAPACITY = 7,
  parameter int CNT_W    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] pcount_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The controller never requests inc when full or dec when empty, so the
  // count cannot wrap and needs no clamping here.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec_i && !inc_i) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign pcount_o = count_q;
  assign full_o   = (count_q == CNT_W'(CAPACITY));
  assign empty_o  = (count_q == '0);

endmodule

// File: rtl/gate_access_controller.sv
// ----------------------------------------------------------------------------
// gate_access_controller
// Arbitrates entry/exit requests against a shared occupancy count, opens the
// granted gate for GATE_CYCLES cycles, raises alarm for ALARM_CYCLES cycles on
// a deny, then spends one COOLDOWN cycle before looking at requests again.
//   clkup         : clock, rising edge
//   reset         : asynchronous active-low reset
//   entry_req     : level request, held until entry_ack / entry_deny
//   exit_req      : level request, held until exit_ack / exit_deny
//   entry_ack     : one-cycle grant pulse     exit_ack  : likewise for exit
//   entry_deny    : one-cycle pulse, full     exit_deny : one-cycle pulse, empty
//   gate_in_open  : entry gate actuator       gate_out_open : exit gate actuator
//   pcount        : current occupancy
//   full_flag     : pcount == CAPACITY        empty_flag : pcount == 0
//   alarm         : deny indicator            busy : FSM not in IDLE
// ----------------------------------------------------------------------------
module gate_access_controller
  import gate_pkg::*;
#(
  parameter int CAPACITY     = 7,
  parameter int CNT_W        = 4,
  parameter int GATE_CYCLES  = 4,
  parameter int ALARM_CYCLES = 2
) (
  input  logic             clkup,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             exit_req,
  output logic             entry_ack,
  output logic             exit_ack,
  output logic             entry_deny,
  output logic             exit_deny,
  output logic             gate_in_open,
  output logic             gate_out_open,
  output logic [CNT_W-1:0] pcount,
  output logic             full_flag,
  output logic             empty_flag,
  output logic             alarm,
  output logic             busy
);

  // Timer counts from N-1 down to 0, so it only needs to hold the larger
  // window length minus one.
  localparam int unsigned WIN_MAX = max2(GATE_CYCLES, ALARM_CYCLES);
  localparam int TMR_W = (WIN_MAX > 1) ? $clog2(WIN_MAX) : 1;

  state_t           state_q, state_d;
  side_t            ptr_q, ptr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             entry_ack_q, entry_ack_d;
  logic             exit_ack_q, exit_ack_d;
  logic             entry_deny_q, entry_deny_d;
  logic             exit_deny_q, exit_deny_d;
  logic             inc, dec;

  logic in_ok, out_ok, in_ref, out_ref;

  occupancy_reg #(
    .CAPACITY (CAPACITY),
    .CNT_W    (CNT_W)
  ) u_occupancy (
    .clk_i    (clkup),
    .rst_ni   (reset),
    .inc_i    (inc),
    .dec_i    (dec),
    .pcount_o (pcount),
    .full_o   (full_flag),
    .empty_o  (empty_flag)
  );

  assign in_ok   = entry_req && !full_flag;
  assign out_ok  = exit_req  && !empty_flag;
  assign in_ref  = entry_req &&  full_flag;
  assign out_ref = exit_req  &&  empty_flag;

  always_comb begin
    logic serve_in;
    logic serve_out;
    state_d      = state_q;
    ptr_d        = ptr_q;
    timer_d      = timer_q;
    entry_ack_d  = 1'b0;
    exit_ack_d   = 1'b0;
    entry_deny_d = 1'b0;
    exit_deny_d  = 1'b0;
    inc          = 1'b0;
    dec          = 1'b0;
    serve_in     = 1'b0;
    serve_out    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_ok && out_ok) begin
          serve_out = (ptr_q == SIDE_OUT);
          serve_in  = (ptr_q == SIDE_IN);
          ptr_d     = (ptr_q == SIDE_IN) ? SIDE_OUT : SIDE_IN;
        end else if (in_ok) begin
          serve_in = 1'b1;
          // A refused request on the other side keeps its turn.
          if (!exit_req) ptr_d = (ptr_q == SIDE_IN) ? SIDE_OUT : SIDE_IN;
        end else if (out_ok) begin
          serve_out = 1'b1;
          if (!entry_req) ptr_d = (ptr_q == SIDE_IN) ? SIDE_OUT : SIDE_IN;
        end else if (out_ref) begin
          state_d     = DENY;
          timer_d     = TMR_W'(ALARM_CYCLES - 1);
          exit_deny_d = 1'b1;
        end else if (in_ref) begin
          state_d      = DENY;
          timer_d      = TMR_W'(ALARM_CYCLES - 1);
          entry_deny_d = 1'b1;
        end

        if (serve_in) begin
          state_d     = OPEN_IN;
          timer_d     = TMR_W'(GATE_CYCLES - 1);
          inc         = 1'b1;
          entry_ack_d = 1'b1;
        end
        if (serve_out) begin
          state_d    = OPEN_OUT;
          timer_d    = TMR_W'(GATE_CYCLES - 1);
          dec        = 1'b1;
          exit_ack_d = 1'b1;
        end
      end

      OPEN_IN, OPEN_OUT, DENY: begin
        if (timer_q == '0) begin
          state_d = COOLDOWN;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      COOLDOWN: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkup or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= SIDE_OUT;
      timer_q      <= '0;
      entry_ack_q  <= 1'b0;
      exit_ack_q   <= 1'b0;
      entry_deny_q <= 1'b0;
      exit_deny_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      timer_q      <= timer_d;
      entry_ack_q  <= entry_ack_d;
      exit_ack_q   <= exit_ack_d;
      entry_deny_q <= entry_deny_d;
      exit_deny_q  <= exit_deny_d;
    end
  end

  // Actuators follow the registered state, so they drop on the same edge as
  // the state change and clear immediately on reset.
  assign gate_in_open  = (state_q == OPEN_IN);
  assign gate_out_open = (state_q == OPEN_OUT);
  assign alarm         = (state_q == DENY);
  assign busy          = (state_q != IDLE);
  assign entry_ack     = entry_ack_q;
  assign exit_ack      = exit_ack_q;
  assign entry_deny    = entry_deny_q;
  assign exit_deny     = exit_deny_q;

endmodule

// File: tb/tb_gate_access_controller.sv
module tb_gate_access_controller;

  logic       clkup = 1'b0;
  logic       reset;
  logic       entry_req, exit_req;
  logic       entry_ack, exit_ack, entry_deny, exit_deny;
  logic       gate_in_open, gate_out_open;
  logic [3:0] pcount;
  logic       full_flag, empty_flag, alarm, busy;

  int n_cmp = 0;
  int n_err = 0;

  gate_access_controller #(
    .CAPACITY     (7),
    .CNT_W        (4),
    .GATE_CYCLES  (4),
    .ALARM_CYCLES (2)
  ) dut (
    .clkup         (clkup),
    .reset         (reset),
    .entry_req     (entry_req),
    .exit_req      (exit_req),
    .entry_ack     (entry_ack),
    .exit_ack      (exit_ack),
    .entry_deny    (entry_deny),
    .exit_deny     (exit_deny),
    .gate_in_open  (gate_in_open),
    .gate_out_open (gate_out_open),
    .pcount        (pcount),
    .full_flag     (full_flag),
    .empty_flag    (empty_flag),
    .alarm         (alarm),
    .busy          (busy)
  );

  always #5 clkup = ~clkup;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Gates and alarm are mutually exclusive at all times.
  always @(negedge clkup) begin
    if (reset === 1'b1) begin
      check_eq("one_hot_actuators",
               32'(int'(gate_in_open) + int'(gate_out_open) + int'(alarm)) <= 32'd1, 32'd1);
    end
  end

  task automatic step();
    @(posedge clkup);
    #1;
  endtask

  // Step until an ack or deny pulse appears, within a cycle budget.
  task automatic wait_event(output logic [3:0] ev);
    ev = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      step();
      if (entry_ack || exit_ack || entry_deny || exit_deny) begin
        ev = {entry_ack, exit_ack, entry_deny, exit_deny};
        $display("txn: entry_ack=%0b exit_ack=%0b entry_deny=%0b exit_deny=%0b pcount=%0d",
                 entry_ack, exit_ack, entry_deny, exit_deny, pcount);
        return;
      end
    end
    check_eq("event_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      step();
      if (!busy) return;
    end
    check_eq("idle_timeout", 32'd0, 32'd1);
  endtask

  logic [3:0] ev;
  int         gate_cnt;
  logic       busy5, busy6, gate_seen;

  initial begin
    reset     = 1'b0;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    repeat (3) step();

    // Reset state
    check_eq("rst_pcount", 32'(pcount), 32'd0);
    check_eq("rst_empty", 32'(empty_flag), 32'd1);
    check_eq("rst_full", 32'(full_flag), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_gates", 32'({gate_in_open, gate_out_open}), 32'd0);
    check_eq("rst_alarm", 32'(alarm), 32'd0);
    check_eq("rst_pulses", 32'({entry_ack, exit_ack, entry_deny, exit_deny}), 32'd0);
    reset = 1'b1;

    // Exit while empty: deny + 2-cycle alarm, count untouched
    exit_req = 1'b1;
    step();
    check_eq("xdeny_pulse", 32'(exit_deny), 32'd1);
    check_eq("xdeny_alarm1", 32'(alarm), 32'd1);
    check_eq("xdeny_pcount", 32'(pcount), 32'd0);
    check_eq("xdeny_empty", 32'(empty_flag), 32'd1);
    check_eq("xdeny_noack", 32'(exit_ack), 32'd0);
    exit_req = 1'b0;
    step();
    check_eq("xdeny_pulse_end", 32'(exit_deny), 32'd0);
    check_eq("xdeny_alarm2", 32'(alarm), 32'd1);
    step();
    check_eq("xdeny_alarm_off", 32'(alarm), 32'd0);
    check_eq("xdeny_cooldown_busy", 32'(busy), 32'd1);
    step();
    check_eq("xdeny_idle", 32'(busy), 32'd0);

    // First entry: precise timing of ack, count, flags, gate window
    entry_req = 1'b1;
    step();
    check_eq("e1_ack", 32'(entry_ack), 32'd1);
    check_eq("e1_pcount", 32'(pcount), 32'd1);
    check_eq("e1_empty", 32'(empty_flag), 32'd0);
    check_eq("e1_busy", 32'(busy), 32'd1);
    entry_req = 1'b0;
    gate_cnt  = int'(gate_in_open);
    busy5     = 1'b0;
    busy6     = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      step();
      if (i == 2) check_eq("e1_ack_one_cycle", 32'(entry_ack), 32'd0);
      gate_cnt += int'(gate_in_open);
      if (i == 5) busy5 = busy;
      if (i == 6) busy6 = busy;
    end
    check_eq("e1_gate_cycles", 32'(gate_cnt), 32'd4);
    check_eq("e1_cooldown_busy", 32'(busy5), 32'd1);
    check_eq("e1_back_idle", 32'(busy6), 32'd0);

    // Six more entries up to capacity
    for (int n = 2; n <= 7; n++) begin
      entry_req = 1'b1;
      wait_event(ev);
      check_eq($sformatf("fill%0d_ack", n), 32'(ev), 32'b1000);
      entry_req = 1'b0;
      wait_idle();
    end
    check_eq("full_pcount", 32'(pcount), 32'd7);
    check_eq("full_flag", 32'(full_flag), 32'd1);
    check_eq("full_not_empty", 32'(empty_flag), 32'd0);

    // Eighth entry is refused
    entry_req = 1'b1;
    step();
    gate_seen = gate_in_open;
    check_eq("edeny_pulse", 32'(entry_deny), 32'd1);
    check_eq("edeny_alarm1", 32'(alarm), 32'd1);
    check_eq("edeny_pcount", 32'(pcount), 32'd7);
    entry_req = 1'b0;
    step();
    gate_seen |= gate_in_open;
    check_eq("edeny_pulse_end", 32'(entry_deny), 32'd0);
    check_eq("edeny_alarm2", 32'(alarm), 32'd1);
    step();
    gate_seen |= gate_in_open;
    check_eq("edeny_alarm_off", 32'(alarm), 32'd0);
    step();
    gate_seen |= gate_in_open;
    check_eq("edeny_idle", 32'(busy), 32'd0);
    check_eq("edeny_no_gate", 32'(gate_seen), 32'd0);
    check_eq("edeny_pcount_kept", 32'(pcount), 32'd7);

    // Pointer now favours entry (toggled on each of 7 lone grants); at full,
    // the grantable exit wins over the refusable entry.
    entry_req = 1'b1;
    exit_req  = 1'b1;
    wait_event(ev);
    check_eq("full_both_exit_first", 32'(ev), 32'b0100);
    check_eq("full_both_pcount", 32'(pcount), 32'd6);
    check_eq("full_both_no_alarm", 32'(alarm), 32'd0);
    exit_req = 1'b0;
    wait_event(ev);
    check_eq("full_both_entry_next", 32'(ev), 32'b1000);
    check_eq("full_both_pcount2", 32'(pcount), 32'd7);
    entry_req = 1'b0;
    wait_idle();

    // Four lone exits bring count to 3, pointer back to exit
    for (int n = 0; n < 4; n++) begin
      exit_req = 1'b1;
      wait_event(ev);
      check_eq($sformatf("drain%0d_ack", n), 32'(ev), 32'b0100);
      exit_req = 1'b0;
      wait_idle();
    end
    check_eq("drain_pcount", 32'(pcount), 32'd3);

    // Simultaneous requests alternate: exit, entry, exit
    entry_req = 1'b1;
    exit_req  = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_event(ev);
      if (r == 1) begin
        check_eq($sformatf("rr%0d_side", r), 32'(ev), 32'b1000);
        check_eq($sformatf("rr%0d_pcount", r), 32'(pcount), 32'd3);
        entry_req = 1'b0;
        step();
        entry_req = 1'b1;
      end else begin
        check_eq($sformatf("rr%0d_side", r), 32'(ev), 32'b0100);
        check_eq($sformatf("rr%0d_pcount", r), 32'(pcount), 32'd2);
        exit_req = 1'b0;
        step();
        if (r == 0) exit_req = 1'b1;
        else entry_req = 1'b0;
      end
      wait_idle();
    end

    // Reset asserted two cycles into an entry window
    entry_req = 1'b1;
    step();
    check_eq("mid_ack", 32'(entry_ack), 32'd1);
    entry_req = 1'b0;
    step();
    check_eq("mid_gate_open", 32'(gate_in_open), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_gate", 32'(gate_in_open), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ack", 32'(entry_ack), 32'd0);
    check_eq("mid_rst_pcount", 32'(pcount), 32'd0);
    check_eq("mid_rst_empty", 32'(empty_flag), 32'd1);
    step();
    reset = 1'b1;
    entry_req = 1'b1;
    step();
    check_eq("post_rst_ack", 32'(entry_ack), 32'd1);
    check_eq("post_rst_pcount", 32'(pcount), 32'd1);
    check_eq("post_rst_gate", 32'(gate_in_open), 32'd1);
    entry_req = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
